// File: rtl/captura_senha_if.sv
// Keypad-side and datapath-side signals of the password capture stage.
// The keypad/controller side drives through master; captura_senha connects through slave.
interface captura_senha_if #(
    parameter int DIGITOS = 4
);
    localparam int AW = $clog2(DIGITOS);

    logic          tecla_valida;
    logic [3:0]    tecla;
    logic          habilita;
    logic          limpa;
    logic [AW-1:0] endereco;
    logic [3:0]    digito;
    logic          funcao_selecionada;
    logic [1:0]    funcao;
    logic [AW:0]   qtd_digitos;
    logic          erro_entrada;
    logic [1:0]    db_estado;

    // Handshake: a key is taken when tecla_valida=1 and habilita=1 at a rising clock edge.
    // There is no back-pressure, so a strobe that is not accepted is lost.
    // funcao_selecionada is a one-cycle pulse, and funcao holds its value until limpa is applied.
    modport master (
        output tecla_valida, tecla, habilita, limpa, endereco,
        input  digito, funcao_selecionada, funcao, qtd_digitos, erro_entrada, db_estado
    );

    modport slave (
        input  tecla_valida, tecla, habilita, limpa, endereco,
        output digito, funcao_selecionada, funcao, qtd_digitos, erro_entrada, db_estado
    );
endinterface

// File: rtl/captura_senha.sv
// Collects keypad digits into a fixed-length password buffer and decodes the verify/configure keys.
// After a function key is taken, the buffer stays frozen for readback until limpa is applied.
module captura_senha #(
    parameter int DIGITOS = 4,
    parameter int TIMEOUT = 50000000
) (
    input logic             clock,
    input logic             reset,
    captura_senha_if.slave  bus
);
    localparam int AW = $clog2(DIGITOS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DIGITOS);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        COLETA    = 2'b00,
        CHEIO     = 2'b01,
        SELECIONA = 2'b10,
        TRAVADO   = 2'b11
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [3:0]    mem_q [DIGITOS];
    logic [3:0]    mem_d [DIGITOS];
    logic [AW:0]   cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [1:0]    funcao_q, funcao_d;
    logic          erro_q, erro_d;
    logic          aceita;

    assign aceita = bus.tecla_valida && bus.habilita;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= COLETA;
            for (int i = 0; i < DIGITOS; i++) mem_q[i] <= '0;
            cnt_q    <= '0;
            tmr_q    <= '0;
            funcao_q <= 2'b00;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            mem_q    <= mem_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            funcao_q <= funcao_d;
            erro_q   <= erro_d;
        end
    end

    // The inactivity timer defaults to zero and advances only while a partial or full entry waits.
    always_comb begin
        estado_d = estado_q;
        mem_d    = mem_q;
        cnt_d    = cnt_q;
        tmr_d    = '0;
        funcao_d = funcao_q;
        erro_d   = 1'b0;
        if (bus.limpa) begin
            estado_d = COLETA;
            mem_d    = '{default: '0};
            cnt_d    = '0;
            funcao_d = 2'b00;
        end else begin
            case (estado_q)
                COLETA, CHEIO: begin
                    if (aceita) begin
                        if (bus.tecla <= 4'd9) begin
                            if (estado_q == COLETA) begin
                                mem_d[cnt_q[AW-1:0]] = bus.tecla;
                                cnt_d = cnt_q + CNT_ONE;
                                if (cnt_d == CNT_FULL) estado_d = CHEIO;
                            end
                        end else begin
                            case (bus.tecla)
                                4'hA, 4'hB: begin
                                    if (estado_q == CHEIO) begin
                                        funcao_d = (bus.tecla == 4'hA) ? 2'b01 : 2'b10;
                                        estado_d = SELECIONA;
                                    end else begin
                                        erro_d = 1'b1;
                                    end
                                end
                                4'hC: begin
                                    estado_d = COLETA;
                                    mem_d    = '{default: '0};
                                    cnt_d    = '0;
                                end
                                4'hD: begin
                                    if (cnt_q != '0) begin
                                        cnt_d = cnt_q - CNT_ONE;
                                        mem_d[cnt_d[AW-1:0]] = '0;
                                        estado_d = COLETA;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end else if (bus.habilita && cnt_q != '0) begin
                        if (tmr_q == TMR_LAST) begin
                            estado_d = COLETA;
                            mem_d    = '{default: '0};
                            cnt_d    = '0;
                        end else begin
                            tmr_d = tmr_q + TW'(1);
                        end
                    end
                end
                SELECIONA: estado_d = TRAVADO;
                TRAVADO:   estado_d = TRAVADO;
                default:   estado_d = COLETA;
            endcase
        end
    end

    // Entries at or above the stored count are always zero, so a direct read is safe.
    always_comb begin
        bus.digito = 4'd0;
        if ({1'b0, bus.endereco} < CNT_FULL) bus.digito = mem_q[bus.endereco];
    end

    assign bus.funcao_selecionada = (estado_q == SELECIONA);
    assign bus.funcao             = funcao_q;
    assign bus.qtd_digitos        = cnt_q;
    assign bus.erro_entrada       = erro_q;
    assign bus.db_estado          = estado_q;
endmodule
